// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the PC sequencer
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    SEQ,
    HOLD,
    REDIR,
    EXC,
    ERET
  } next_src_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC source priority encoder and redirect alignment check
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INC    = 4
) (
  input  logic              run,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              stall_i,
  input  logic              imem_ready_i,
  output next_src_e         src,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  logic target_misaligned;

  assign target_misaligned = (redirect_pc_i & ALIGN_MASK) != '0;

  // Strict priority: exception first; outside RUN only an exception matters.
  always_comb begin
    src      = HOLD;
    misalign = 1'b0;
    if (exc_i) begin
      src = EXC;
    end else if (!run) begin
      src = HOLD;
    end else if (eret_i) begin
      src = ERET;
    end else if (redirect_i) begin
      if (target_misaligned) begin
        src      = EXC;
        misalign = 1'b1;
      end else begin
        src = REDIR;
      end
    end else if (stall_i || !imem_ready_i) begin
      src = HOLD;
    end else begin
      src = SEQ;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with redirect, exception and halt control
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                INC          = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_seq_o,
  output logic              pc_valid_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              flush_o,
  output logic              misalign_o
);

  state_e            state, state_nxt;
  next_src_e         src;
  logic              sel_misalign;
  logic [ADDR_W-1:0] pc_nxt, epc_nxt;
  logic              valid_nxt, flush_nxt, misalign_nxt;

  assign pc_next_seq_o = pc_o + ADDR_W'(INC);

  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .INC    (INC)
  ) u_sel (
    .run           (state == RUN),
    .exc_i         (exc_i),
    .eret_i        (eret_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem_ready_i  (imem_ready_i),
    .src           (src),
    .misalign      (sel_misalign)
  );

  // Next state, next PC/EPC and the one-cycle flush/misalign pulses.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_o;
    epc_nxt      = epc_o;
    flush_nxt    = 1'b0;
    misalign_nxt = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, HALT: begin
        case (src)
          SEQ: pc_nxt = pc_next_seq_o;
          REDIR: begin
            pc_nxt    = redirect_pc_i;
            flush_nxt = 1'b1;
          end
          ERET: begin
            pc_nxt    = epc_o;
            flush_nxt = 1'b1;
          end
          EXC: begin
            // A misaligned redirect records the bad target rather than the current PC.
            epc_nxt      = sel_misalign ? redirect_pc_i : pc_o;
            pc_nxt       = EXC_VECTOR;
            flush_nxt    = 1'b1;
            misalign_nxt = sel_misalign;
            state_nxt    = RUN;
          end
          default: pc_nxt = pc_o;
        endcase
        // Halt only takes effect when no flush event claimed this cycle.
        if (state == RUN && halt_i && !flush_nxt) state_nxt = HALT;
        if (state == HALT && resume_i) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
    valid_nxt = (state_nxt == RUN);
  end

  // State and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc_o       <= RESET_VECTOR;
      epc_o      <= '0;
      pc_valid_o <= 1'b0;
      flush_o    <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_o       <= pc_nxt;
      epc_o      <= epc_nxt;
      pc_valid_o <= valid_nxt;
      flush_o    <= flush_nxt;
      misalign_o <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed bench for pc_sequencer at 32-bit and 8-bit widths
module tb_pc_sequencer;

  localparam int S_BOOT = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;
  localparam logic [31:0] EV32 = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect = 1'b0, exc = 1'b0, eret = 1'b0;
  logic        halt = 1'b0, resume = 1'b0, ready = 1'b1;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] pc32, nseq32, epc32;
  logic        v32, f32, m32;
  logic [7:0]  pc8, nseq8, epc8;
  logic        v8, f8, m8;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_state [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_epc   [2];
  logic        m_valid [2];
  logic        m_flush [2];
  logic        m_mis   [2];

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .exc_i(exc), .eret_i(eret), .halt_i(halt), .resume_i(resume), .imem_ready_i(ready),
    .pc_o(pc32), .pc_next_seq_o(nseq32), .pc_valid_o(v32), .epc_o(epc32),
    .flush_o(f32), .misalign_o(m32)
  );

  pc_sequencer #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc[7:0]),
    .exc_i(exc), .eret_i(eret), .halt_i(halt), .resume_i(resume), .imem_ready_i(ready),
    .pc_o(pc8), .pc_next_seq_o(nseq8), .pc_valid_o(v8), .epc_o(epc8),
    .flush_o(f8), .misalign_o(m8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] width_mask(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = S_BOOT;
      m_pc[k]    = 32'h0;
      m_epc[k]   = 32'h0;
      m_valid[k] = 1'b0;
      m_flush[k] = 1'b0;
      m_mis[k]   = 1'b0;
    end
  endtask

  // One clock edge of the architectural behaviour, for each width.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] msk, tgt, ev;
      msk = width_mask(k);
      tgt = redirect_pc & msk;
      ev  = EV32 & msk;
      m_flush[k] = 1'b0;
      m_mis[k]   = 1'b0;
      if (m_state[k] == S_BOOT) begin
        m_state[k] = S_RUN;
      end else if (m_state[k] == S_RUN) begin
        if (exc) begin
          m_epc[k] = m_pc[k]; m_pc[k] = ev; m_flush[k] = 1'b1;
        end else if (eret) begin
          m_pc[k] = m_epc[k]; m_flush[k] = 1'b1;
        end else if (redirect) begin
          m_flush[k] = 1'b1;
          if (tgt % 4 == 0) m_pc[k] = tgt;
          else begin
            m_epc[k] = tgt; m_pc[k] = ev; m_mis[k] = 1'b1;
          end
        end else begin
          if (!stall && ready) m_pc[k] = (m_pc[k] + 32'd4) & msk;
          if (halt) m_state[k] = S_HALT;
        end
      end else begin
        if (exc) begin
          m_epc[k] = m_pc[k]; m_pc[k] = ev; m_flush[k] = 1'b1; m_state[k] = S_RUN;
        end else if (resume) begin
          m_state[k] = S_RUN;
        end
      end
      m_valid[k] = (m_state[k] == S_RUN);
    end
  endtask

  task automatic compare_all();
    check("pc32",    {32'h0, pc32},   {32'h0, m_pc[0]});
    check("nseq32",  {32'h0, nseq32}, {32'h0, m_pc[0] + 32'd4});
    check("valid32", {63'h0, v32},    {63'h0, m_valid[0]});
    check("epc32",   {32'h0, epc32},  {32'h0, m_epc[0]});
    check("flush32", {63'h0, f32},    {63'h0, m_flush[0]});
    check("mis32",   {63'h0, m32},    {63'h0, m_mis[0]});
    check("pc8",     {56'h0, pc8},    {32'h0, m_pc[1]});
    check("nseq8",   {56'h0, nseq8},  {32'h0, (m_pc[1] + 32'd4) & 32'hFF});
    check("valid8",  {63'h0, v8},     {63'h0, m_valid[1]});
    check("epc8",    {56'h0, epc8},   {32'h0, m_epc[1]});
    check("flush8",  {63'h0, f8},     {63'h0, m_flush[1]});
    check("mis8",    {63'h0, m8},     {63'h0, m_mis[1]});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    stall = 1'b0; redirect = 1'b0; exc = 1'b0; eret = 1'b0;
    halt = 1'b0; resume = 1'b0; ready = 1'b1; redirect_pc = 32'h0;
  endtask

  // Hold reset over one edge, release just after it, then observe the BOOT cycle.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    clear_inputs();
    do_reset();
    check("boot_valid", {63'h0, v32}, 64'h0);

    step(); check("first_pc", {32'h0, pc32}, 64'h0);
    step(); check("second_pc", {32'h0, pc32}, 64'h4);
    step(); check("third_pc", {32'h0, pc32}, 64'h8);

    ready = 1'b0;
    step();
    stall = 1'b1;
    step(); step();
    check("hold_pc", {32'h0, pc32}, 64'h8);
    ready = 1'b1; stall = 1'b0;
    step(); check("resume_pc", {32'h0, pc32}, 64'hC);

    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    step(); check("redir_pc", {32'h0, pc32}, 64'h100); check("redir_flush", {63'h0, f32}, 64'h1);
    redirect = 1'b0;
    step(); check("flush_pulse", {63'h0, f32}, 64'h0);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
    step();
    check("mis_pc", {32'h0, pc32}, {32'h0, EV32});
    check("mis_epc", {32'h0, epc32}, 64'h102);
    check("mis_flag", {63'h0, m32}, 64'h1);

    redirect_pc = 32'h40;
    step();
    redirect = 1'b1; redirect_pc = 32'h200; exc = 1'b1; stall = 1'b1;
    step();
    check("exc_pc", {32'h0, pc32}, {32'h0, EV32});
    check("exc_epc", {32'h0, epc32}, 64'h40);
    clear_inputs();
    step(); step();
    eret = 1'b1;
    step(); check("eret_pc", {32'h0, pc32}, 64'h40);
    clear_inputs();

    redirect = 1'b1; redirect_pc = 32'hFC;
    step();
    redirect = 1'b0;
    step(); check("wrap8", {56'h0, pc8}, 64'h0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    step(); check("halt_valid", {63'h0, v8}, 64'h0);
    exc = 1'b1; resume = 1'b1;
    step();
    check("halt_exc_pc8", {56'h0, pc8}, 64'h80);
    check("halt_exc_valid", {63'h0, v8}, 64'h1);
    clear_inputs();
    step(); step();

    #2 rst = 1'b1;
    #1;
    check("async_pc32", {32'h0, pc32}, 64'h0);
    check("async_pc8", {56'h0, pc8}, 64'h0);
    check("async_valid", {63'h0, v32}, 64'h0);
    check("async_flush", {63'h0, f32}, 64'h0);
    do_reset();
    step();

    for (int i = 0; i < 2000; i++) begin
      exc      = ($urandom_range(0, 15) == 0);
      eret     = ($urandom_range(0, 15) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      halt     = ($urandom_range(0, 19) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 3) != 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 1) == 1) redirect_pc[1:0] = 2'b00;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
